// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding req/ack
// read channel into a 2-entry {pc, instr} queue, and drives the IF/ID register.
module fetch_unit #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          INRS,
  input  logic          Stall_PC,
  input  logic          Stall_IF_ID,
  input  logic          Redirect,
  input  logic [AW-1:0] Redirect_PC,
  output logic          IMEM_REQ,
  output logic [AW-1:0] IMEM_ADDR,
  input  logic          IMEM_ACK,
  input  logic [DW-1:0] IMEM_RDATA,
  output logic [DW-1:0] IF_ID_INSTR,
  output logic [AW-1:0] IF_ID_PC,
  output logic          IF_ID_VALID,
  output logic [1:0]    dbg_state
);

  // Handshake: IMEM_REQ/IMEM_ADDR are registered and held until a cycle with
  // IMEM_ACK=1 while IMEM_REQ=1; that edge completes the read with IMEM_RDATA.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] fetch_pc, fetch_pc_nxt;
  logic          req_nxt;
  logic [AW-1:0] addr_nxt;
  logic [1:0]    count, count_nxt;
  logic [AW-1:0] q_pc      [2];
  logic [DW-1:0] q_instr   [2];
  logic [AW-1:0] q_pc_nxt  [2];
  logic [DW-1:0] q_instr_nxt [2];

  logic          push, pop, issue_ok, wr_slot;
  logic [AW-1:0] redirect_pc_al, addr_inc;

  assign issue_ok       = !INRS && !Stall_PC && !Redirect;
  assign push           = (state == S_WAIT) && IMEM_ACK && !Redirect;
  assign pop            = !Redirect && !Stall_IF_ID && (count != 2'd0);
  assign redirect_pc_al = Redirect_PC & ~AW'(3);
  assign addr_inc       = IMEM_ADDR + AW'(4);
  // Writes land behind the surviving entry; a full queue never sees a push.
  assign wr_slot        = (count == 2'd1) && !pop;
  assign dbg_state      = state;

  always_comb begin
    q_pc_nxt    = q_pc;
    q_instr_nxt = q_instr;
    count_nxt   = count;
    if (Redirect) begin
      count_nxt = 2'd0;
    end else begin
      if (pop) begin
        q_pc_nxt[0]    = q_pc[1];
        q_instr_nxt[0] = q_instr[1];
      end
      if (push) begin
        if (wr_slot) begin
          q_pc_nxt[1]    = IMEM_ADDR;
          q_instr_nxt[1] = IMEM_RDATA;
        end else begin
          q_pc_nxt[0]    = IMEM_ADDR;
          q_instr_nxt[0] = IMEM_RDATA;
        end
      end
      count_nxt = count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (issue_ok && (count < 2'd2)) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (IMEM_ACK) begin
          // Back-to-back issue is judged on the occupancy after this edge.
          if (issue_ok && (count_nxt < 2'd2)) state_nxt = S_WAIT;
          else                                 state_nxt = S_IDLE;
        end else if (Redirect) begin
          state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (IMEM_ACK) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_nxt      = (state_nxt != S_IDLE);
    addr_nxt     = IMEM_ADDR;
    fetch_pc_nxt = fetch_pc;
    if (state == S_IDLE && state_nxt == S_WAIT) begin
      addr_nxt = fetch_pc;
    end else if (state == S_WAIT && IMEM_ACK && state_nxt == S_WAIT) begin
      addr_nxt = addr_inc;
    end
    if (Redirect)  fetch_pc_nxt = redirect_pc_al;
    else if (push) fetch_pc_nxt = addr_inc;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      IMEM_REQ   <= 1'b0;
      IMEM_ADDR  <= RESET_PC;
      fetch_pc   <= RESET_PC;
      count      <= 2'd0;
      q_pc[0]    <= '0;
      q_pc[1]    <= '0;
      q_instr[0] <= '0;
      q_instr[1] <= '0;
    end else begin
      IMEM_REQ   <= req_nxt;
      IMEM_ADDR  <= addr_nxt;
      fetch_pc   <= fetch_pc_nxt;
      count      <= count_nxt;
      q_pc       <= q_pc_nxt;
      q_instr    <= q_instr_nxt;
    end
  end

  // A push into an empty queue reaches IF/ID one edge later, never bypassed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      IF_ID_INSTR <= '0;
      IF_ID_PC    <= '0;
      IF_ID_VALID <= 1'b0;
    end else if (Redirect) begin
      IF_ID_VALID <= 1'b0;
    end else if (!Stall_IF_ID) begin
      if (count != 2'd0) begin
        IF_ID_INSTR <= q_instr[0];
        IF_ID_PC    <= q_pc[0];
        IF_ID_VALID <= 1'b1;
      end else begin
        IF_ID_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory responder, queue-based
// model of the fetch stream checked every cycle, plus directed literal checks.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inrs = 1'b0;
  logic        stall_pc = 1'b0;
  logic        stall_if_id = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic [1:0]  dbg_state;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  fetch_unit #(.AW(32), .DW(32), .RESET_PC(RST_PC)) dut (
    .CLK(clk), .RST(rst), .INRS(inrs), .Stall_PC(stall_pc),
    .Stall_IF_ID(stall_if_id), .Redirect(redirect), .Redirect_PC(redirect_pc),
    .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr), .IMEM_ACK(imem_ack),
    .IMEM_RDATA(imem_rdata), .IF_ID_INSTR(if_id_instr), .IF_ID_PC(if_id_pc),
    .IF_ID_VALID(if_id_valid), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int   lat = 0;
  int   wait_left = 0;
  logic prev_req = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst || !imem_req) begin
        imem_ack = 1'b0;
      end else if (!prev_req || imem_ack) begin
        wait_left = lat;
        imem_ack  = (lat == 0);
      end else begin
        if (wait_left > 0) wait_left--;
        imem_ack = (wait_left == 0);
      end
      prev_req = imem_req && !rst;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [31:0] exp_q[$];
  logic        m_out = 1'b0;
  logic        m_discard = 1'b0;
  logic [31:0] m_addr = RST_PC;
  logic [31:0] m_next = RST_PC;
  logic        m_v = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] head;
  int          pre_cnt;
  logic        can_issue;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
      chk("rst_pc", if_id_pc, 32'h0);
      chk("rst_instr", if_id_instr, 32'h0);
      exp_q.delete();
      m_out = 1'b0; m_discard = 1'b0; m_addr = RST_PC; m_next = RST_PC;
      m_v = 1'b0; m_pc = 32'h0; m_instr = 32'h0;
    end else begin
      chk("req", {31'b0, imem_req}, {31'b0, m_out});
      if (m_out) chk("addr", imem_addr, m_addr);
      chk("valid", {31'b0, if_id_valid}, {31'b0, m_v});
      chk("if_pc", if_id_pc, m_pc);
      chk("if_instr", if_id_instr, m_instr);

      pre_cnt   = exp_q.size();
      can_issue = !inrs && !stall_pc && !redirect;
      if (redirect) begin
        m_v = 1'b0;
      end else if (!stall_if_id) begin
        if (exp_q.size() > 0) begin
          head = exp_q.pop_front();
          m_v = 1'b1; m_pc = head; m_instr = instr_of(head);
        end else begin
          m_v = 1'b0;
        end
      end
      if (m_out && imem_ack && !m_discard && !redirect) begin
        exp_q.push_back(m_addr);
        m_next = m_addr + 32'd4;
      end
      if (redirect) begin
        exp_q.delete();
        m_next = redirect_pc & ~32'h3;
      end
      if (m_out && !imem_ack) begin
        if (redirect) m_discard = 1'b1;
      end else if (m_out) begin
        m_out = !m_discard && can_issue && (exp_q.size() < 2);
        m_discard = 1'b0;
        if (m_out) m_addr = m_next;
      end else begin
        m_out = can_issue && (pre_cnt < 2);
        if (m_out) m_addr = m_next;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_req(input logic want, input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (imem_req == want) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, {31'b0, seen}, 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic seen;
    step(2);
    chk("lit_reset_req", {31'b0, imem_req}, 32'd0);
    chk("lit_reset_addr", imem_addr, 32'h100);
    chk("lit_reset_valid", {31'b0, if_id_valid}, 32'd0);
    chk("lit_reset_state", {30'b0, dbg_state}, 32'd0);
    rst = 1'b0;

    // zero-wait streaming from RESET_PC
    step(1);
    chk("lit_e1_req", {31'b0, imem_req}, 32'd1);
    chk("lit_e1_addr", imem_addr, 32'h100);
    step(1);
    chk("lit_e2_addr", imem_addr, 32'h104);
    chk("lit_e2_valid", {31'b0, if_id_valid}, 32'd0);
    step(1);
    chk("lit_e3_addr", imem_addr, 32'h108);
    chk("lit_e3_valid", {31'b0, if_id_valid}, 32'd1);
    chk("lit_e3_pc", if_id_pc, 32'h100);
    chk("lit_e3_instr", if_id_instr, 32'hC0DE_0100);
    step(1);
    chk("lit_e4_pc", if_id_pc, 32'h104);

    // IF/ID stall: queue fills, issue stops, then drains in order
    stall_if_id = 1'b1;
    step(5);
    chk("lit_stall_pc", if_id_pc, 32'h104);
    chk("lit_stall_valid", {31'b0, if_id_valid}, 32'd1);
    chk("lit_stall_req", {31'b0, imem_req}, 32'd0);
    stall_if_id = 1'b0;
    step(1);
    chk("lit_rel_pc0", if_id_pc, 32'h108);
    step(1);
    chk("lit_rel_pc1", if_id_pc, 32'h10C);
    chk("lit_rel_valid", {31'b0, if_id_valid}, 32'd1);

    // PC stall and pipeline-init hold mid-stream
    step(6);
    stall_pc = 1'b1;
    step(3);
    stall_pc = 1'b0;
    step(4);
    inrs = 1'b1;
    step(2);
    inrs = 1'b0;
    step(4);

    // 3 wait cycles per request
    lat = 3;
    step(20);
    stall_if_id = 1'b1;
    step(6);
    stall_if_id = 1'b0;
    step(10);

    // redirect while waiting on a slow read -> discard
    lat = 6;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (imem_req && !imem_ack) begin
        seen = 1'b1;
        break;
      end
    end
    chk("lit_wait_found", {31'b0, seen}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step(1);
    redirect = 1'b0;
    chk("lit_disc_req", {31'b0, imem_req}, 32'd1);
    chk("lit_disc_state", {30'b0, dbg_state}, 32'd2);
    chk("lit_disc_valid", {31'b0, if_id_valid}, 32'd0);
    wait_req(1'b0, 20, "lit_disc_done");
    wait_req(1'b1, 5, "lit_refetch_req");
    chk("lit_refetch_addr", imem_addr, 32'h200);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (if_id_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("lit_first_after_redir", {31'b0, seen}, 32'd1);
    chk("lit_first_pc", if_id_pc, 32'h200);

    // redirect coinciding with ACK, unaligned target
    lat = 2;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (imem_ack) begin
        seen = 1'b1;
        break;
      end
    end
    chk("lit_ack_found", {31'b0, seen}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h203;
    step(1);
    redirect = 1'b0;
    chk("lit_ackredir_req", {31'b0, imem_req}, 32'd0);
    chk("lit_ackredir_valid", {31'b0, if_id_valid}, 32'd0);
    step(1);
    chk("lit_ackredir_req2", {31'b0, imem_req}, 32'd1);
    chk("lit_ackredir_addr", imem_addr, 32'h200);
    step(12);

    // asynchronous reset in the middle of a read, then INRS hold
    lat = 5;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (imem_req && !imem_ack) begin
        seen = 1'b1;
        break;
      end
    end
    chk("lit_wait2_found", {31'b0, seen}, 32'd1);
    rst = 1'b1;
    #1;
    chk("lit_arst_req", {31'b0, imem_req}, 32'd0);
    chk("lit_arst_addr", imem_addr, 32'h100);
    chk("lit_arst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("lit_arst_pc", if_id_pc, 32'h0);
    inrs = 1'b1;
    lat = 0;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("lit_inrs_noreq", {31'b0, imem_req}, 32'd0);
    end
    inrs = 1'b0;
    step(1);
    chk("lit_restart_req", {31'b0, imem_req}, 32'd1);
    chk("lit_restart_addr", imem_addr, 32'h100);
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
